// File: rtl/spm_arbiter.sv
// Two-master scratchpad arbiter: CPU (m0) has priority, the loader/debug port (m1)
// gets one boosted grant after STARVE_LIMIT consecutive denied cycles.
module spm_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_byteena,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_byteena,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cpu_stall,
  output logic              spm_rden,
  output logic              spm_wren,
  output logic [ADDR_W-1:0] spm_addr,
  output logic [3:0]        spm_byteena,
  output logic [DATA_W-1:0] spm_wdata,
  input  logic [DATA_W-1:0] spm_q
);

  typedef enum logic {NORMAL, BOOST} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       m0_vld_p1;
  logic       m1_vld_p1;

  // Grant decision: same-cycle handshake, priority chosen by the FSM state.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (state == BOOST) begin
        m1_gnt = m1_req;
        m0_gnt = m0_req & ~m1_req;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req & ~m0_req;
      end
    end
  end

  assign spm_addr    = m1_gnt ? m1_addr    : m0_addr;
  assign spm_byteena = m1_gnt ? m1_byteena : m0_byteena;
  assign spm_wdata   = m1_gnt ? m1_wdata   : m0_wdata;
  assign spm_wren    = (m0_gnt & m0_we)  | (m1_gnt & m1_we);
  assign spm_rden    = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
  assign cpu_stall   = ~rst & m0_req & ~m0_gnt;

  // Stage p0 -> p1: read grants become the read-return valids, aligned with spm_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= NORMAL;
      wait_cnt  <= 4'd0;
      m0_vld_p1 <= 1'b0;
      m1_vld_p1 <= 1'b0;
    end else begin
      m0_vld_p1 <= m0_gnt & ~m0_we;
      m1_vld_p1 <= m1_gnt & ~m1_we;
      case (state)
        NORMAL: begin
          if (m1_req && !m1_gnt) begin
            if (wait_cnt == 4'(STARVE_LIMIT - 1)) state <= BOOST;
            wait_cnt <= wait_cnt + 4'd1;
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        BOOST: begin
          // One boosted grant only, or give up the boost if m1 withdraws.
          if (m1_gnt || !m1_req) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
          end
        end
        default: begin
          state    <= NORMAL;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Masking with rst drops a return that was in flight when reset arrived.
  assign m0_rvalid = m0_vld_p1 & ~rst;
  assign m1_rvalid = m1_vld_p1 & ~rst;
  assign m0_rdata  = m0_rvalid ? spm_q : '0;
  assign m1_rdata  = m1_rvalid ? spm_q : '0;

endmodule

// File: tb/tb_spm_arbiter.sv
// Bench for spm_arbiter: vector table, directed corner sequences and a randomized
// run against a priority/starvation reference model with a behavioural SPM.
module tb_spm_arbiter;
  localparam int LIMIT = 4;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [3:0]    m0_byteena = '0, m1_byteena = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, cpu_stall, spm_rden, spm_wren;
  logic [31:0]   m0_rdata, m1_rdata, spm_wdata;
  logic [31:0]   spm_q = '0;
  logic [AW-1:0] spm_addr;
  logic [3:0]    spm_byteena;

  always #5 clk = ~clk;

  spm_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteena(m0_byteena),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteena(m1_byteena),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .cpu_stall(cpu_stall), .spm_rden(spm_rden), .spm_wren(spm_wren),
    .spm_addr(spm_addr), .spm_byteena(spm_byteena), .spm_wdata(spm_wdata), .spm_q(spm_q)
  );

  // Behavioural SPM with registered read data and byte-enabled writes.
  logic [31:0] mem [0:(1<<AW)-1];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (spm_wren) mem[spm_addr] <= merge(mem[spm_addr], spm_wdata, spm_byteena);
    if (spm_rden) spm_q <= mem[spm_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who has priority, how long m1 has been starved, pending reads.
  int          pri = 0;
  int          starve = 0;
  bit          pend0 = 0, pend1 = 0;
  logic [31:0] exp0 = '0, exp1 = '0;

  task automatic model_check();
    bit g0, g1, ev0, ev1;
    g0 = 0; g1 = 0;
    if (!rst) begin
      if (pri == 1) begin g1 = m1_req; g0 = m0_req && !m1_req; end
      else          begin g0 = m0_req; g1 = m1_req && !m0_req; end
    end
    ev0 = pend0 && !rst;
    ev1 = pend1 && !rst;
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("cpu_stall", 32'(cpu_stall), 32'(!rst && m0_req && !g0));
    chk("spm_rden", 32'(spm_rden), 32'((g0 && !m0_we) || (g1 && !m1_we)));
    chk("spm_wren", 32'(spm_wren), 32'((g0 && m0_we) || (g1 && m1_we)));
    chk("spm_addr", 32'(spm_addr), g1 ? 32'(m1_addr) : 32'(m0_addr));
    chk("spm_byteena", 32'(spm_byteena), g1 ? 32'(m1_byteena) : 32'(m0_byteena));
    chk("spm_wdata", spm_wdata, g1 ? m1_wdata : m0_wdata);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
    chk("m0_rdata", m0_rdata, ev0 ? exp0 : 32'h0);
    chk("m1_rdata", m1_rdata, ev1 ? exp1 : 32'h0);
    if (rst) begin
      pri = 0; starve = 0; pend0 = 0; pend1 = 0;
    end else begin
      pend0 = g0 && !m0_we;
      pend1 = g1 && !m1_we;
      if (pend0) exp0 = mem[m0_addr];
      if (pend1) exp1 = mem[m1_addr];
      if (pri == 1) begin
        if (g1 || !m1_req) begin pri = 0; starve = 0; end
      end else if (m1_req && !g1) begin
        starve++;
        if (starve == LIMIT) pri = 1;
      end else begin
        starve = 0;
      end
    end
  endtask

  task automatic drive(bit r, bit q0, bit w0, logic [AW-1:0] a0, logic [3:0] b0, logic [31:0] d0,
                       bit q1, bit w1, logic [AW-1:0] a1, logic [3:0] b1, logic [31:0] d1);
    @(posedge clk);
    #1;
    rst = r;
    m0_req = q0; m0_we = w0; m0_addr = a0; m0_byteena = b0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_addr = a1; m1_byteena = b1; m1_wdata = d1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(bit r);
    drive(r, 0, 0, '0, 4'h0, 32'h0, 0, 0, '0, 4'h0, 32'h0);
  endtask

  task automatic both_read(bit r, logic [AW-1:0] a0, logic [AW-1:0] a1);
    drive(r, 1, 0, a0, 4'hF, 32'h0, 1, 0, a1, 4'hF, 32'h0);
  endtask

  typedef struct {
    bit rst; bit r0; bit r1;
    bit g0;  bit g1; bit stall;
  } vec_t;

  vec_t tbl[16];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h005] = 32'hFFFFFFFF;
    mem[12'h020] = 32'hA0A0A0A0;
    mem[12'h030] = 32'hB1B1B1B1;

    tbl[0]  = '{1, 1, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 1, 1};
    tbl[7]  = '{0, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 1, 1, 1, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 1, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 1, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].r0, 0, AW'(i), 4'hF, 32'h0, tbl[i].r1, 0, AW'(i + 1), 4'hF, 32'h0);
      sample();
      chk($sformatf("tbl%0d_m0_gnt", i), 32'(m0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_m1_gnt", i), 32'(m1_gnt), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_stall", i), 32'(cpu_stall), 32'(tbl[i].stall));
    end

    // Single CPU read.
    drive(0, 1, 0, 12'h010, 4'hF, 32'h0, 0, 0, '0, 4'h0, 32'h0);
    sample();
    chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    idle(0);
    sample();
    chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);

    // Partial write then read back through m1.
    drive(0, 0, 0, '0, 4'h0, 32'h0, 1, 1, 12'h005, 4'b0011, 32'h12345678);
    sample();
    chk("wr_spm_wren", 32'(spm_wren), 32'd1);
    drive(0, 0, 0, '0, 4'h0, 32'h0, 1, 0, 12'h005, 4'hF, 32'h0);
    sample();
    chk("wr_no_rvalid", 32'(m1_rvalid), 32'd0);
    idle(0);
    sample();
    chk("wr_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("wr_m1_rdata", m1_rdata, 32'hFFFF5678);

    // Alternating read masters, no bubbles.
    drive(0, 1, 0, 12'h020, 4'hF, 32'h0, 0, 0, '0, 4'h0, 32'h0);
    sample();
    drive(0, 0, 0, '0, 4'h0, 32'h0, 1, 0, 12'h030, 4'hF, 32'h0);
    sample();
    chk("alt_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("alt_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("alt_m0_rdata", m0_rdata, 32'hA0A0A0A0);
    chk("alt_m1_rvalid0", 32'(m1_rvalid), 32'd0);
    idle(0);
    sample();
    chk("alt_m1_rvalid", 32'(m1_rvalid), 32'd1);
    chk("alt_m1_rdata", m1_rdata, 32'hB1B1B1B1);
    chk("alt_m0_rvalid0", 32'(m0_rvalid), 32'd0);

    // Reset arriving right after a boosted m1 read.
    idle(1);
    sample();
    for (int i = 0; i < LIMIT; i++) begin
      both_read(0, 12'h020, 12'h030);
      sample();
    end
    both_read(0, 12'h020, 12'h030);
    sample();
    chk("boost_m1_gnt", 32'(m1_gnt), 32'd1);
    chk("boost_stall", 32'(cpu_stall), 32'd1);
    both_read(1, 12'h020, 12'h030);
    sample();
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
    both_read(0, 12'h020, 12'h030);
    sample();
    chk("postrst_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("postrst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    for (int i = 1; i < LIMIT; i++) begin
      both_read(0, 12'h020, 12'h030);
      sample();
      chk("postrst_cnt_m0", 32'(m0_gnt), 32'd1);
    end
    both_read(0, 12'h020, 12'h030);
    sample();
    chk("postrst_cnt_m1", 32'(m1_gnt), 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
            4'($urandom), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)),
            4'($urandom), $urandom);
      sample();
    end

    // Idle bus.
    for (int i = 0; i < 4; i++) begin
      idle(0);
      sample();
      chk("idle_strobes", 32'({spm_rden, spm_wren}), 32'd0);
      chk("idle_gnts", 32'({m0_gnt, m1_gnt}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spm_arbiter.md
SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, legal 1..15; the number of consecutive denied cycles for m1 before m1 is boosted.
REQ-002 Parameter: ADDR_W, default 12; SPM word-address width (byte address bits [13:2]).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 m0_req/m0_we  in  1/1  CPU data-port request; write when m0_we=1, else read.
REQ-006 m0_addr/m0_byteena/m0_wdata  in  ADDR_W/4/32  CPU word address, byte enables, write data.
REQ-007 m0_gnt/m0_rvalid  out  1/1  CPU access accepted this cycle / CPU read data valid.
REQ-008 m0_rdata  out  32  CPU read data.
REQ-009 m1_req, m1_we, m1_addr, m1_byteena, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: loader/debug port, same widths and meanings as the m0 signals.
REQ-010 cpu_stall  out  1  pipeline stall request to cpu_ctrl.
REQ-011 spm_rden/spm_wren  out  1/1  SPM read/write strobes.
REQ-012 spm_addr/spm_byteena/spm_wdata  out  ADDR_W/4/32  SPM address, byte enables, write data.
REQ-013 spm_q  in  32  SPM registered read data, valid one cycle after spm_rden.

Function
REQ-014 Request and grant are in the same cycle: a transfer occurs in any cycle where mX_req=1 and mX_gnt=1.
REQ-015 At most one of m0_gnt and m1_gnt SHALL be 1 in any cycle.
REQ-016 FSM states: NORMAL (m0 has priority) and BOOST (m1 has priority); reset state is NORMAL.
REQ-017 In NORMAL: m0_gnt=m0_req; m1_gnt=m1_req & ~m0_req.
REQ-018 In BOOST: m1_gnt=m1_req; m0_gnt=m0_req & ~m1_req.
REQ-019 Counter wait_cnt (4 bits): increments each cycle in which m1_req=1 and m1_gnt=0; clears to 0 when m1_gnt=1 or m1_req=0.
REQ-020 NORMAL->BOOST on the clock edge where m1_req=1, m1_gnt=0 and wait_cnt==STARVE_LIMIT-1.
REQ-021 BOOST->NORMAL after exactly one m1 grant, or when m1_req=0 in BOOST; wait_cnt clears on either exit.
REQ-022 SPM muxing is combinational from the granted master: spm_addr, spm_byteena and spm_wdata follow the winner; with no grant they hold the m0 values.
REQ-023 spm_wren = granted & we; spm_rden = granted & ~we; both 0 when there is no grant.
REQ-024 Read return: mX_rvalid is registered and equals 1 exactly one cycle after an mX read grant; it is never asserted for writes.
REQ-025 mX_rdata = spm_q when mX_rvalid=1, else 32'h0.
REQ-026 Back-to-back reads from alternating masters SHALL return data to the correct master with no bubbles.
REQ-027 cpu_stall = m0_req & ~m0_gnt (combinational).
REQ-028 The arbiter performs no address-conflict checking; write-then-read ordering is guaranteed by grant order.

Reset
REQ-029 While rst=1: m0_gnt, m1_gnt, spm_rden, spm_wren and cpu_stall are forced to 0.
REQ-030 On a clock edge with rst=1: state=NORMAL, wait_cnt=0, m0_rvalid=m1_rvalid=0.
REQ-031 Reset asserted mid-BOOST or during a pending read SHALL drop the rvalid that would otherwise follow; no data is delivered after reset.

Verification
REQ-032 Single read: m0 read at addr 12'h010, SPM holds 32'hDEADBEEF -> m0_gnt=1 in cycle 0; m0_rvalid=1 with m0_rdata=32'hDEADBEEF in cycle 1; m1_rvalid stays 0.
REQ-033 Contention, STARVE_LIMIT=4: m0_req and m1_req held at 1 -> m0 is granted in cycles 0-3; m1 is granted in cycle 4 with cpu_stall=1; m0 is granted again from cycle 5; the pattern repeats every 5 cycles.
REQ-034 Write then read: m1 writes 32'h12345678 with byteena 4'b0011 to addr 5 (old value 32'hFFFFFFFF), then m1 reads addr 5 -> m1_rdata=32'hFFFF5678.
REQ-035 Alternating reads: m0 reads in cycle 0, m1 reads in cycle 1 -> m0_rvalid in cycle 1, m1_rvalid in cycle 2, each with its own data.
REQ-036 Reset mid-operation: rst=1 in the cycle after an m1 read grant while in BOOST -> m1_rvalid=0, state NORMAL, wait_cnt=0 on the next edge.
REQ-037 Idle: no requests -> spm_rden=spm_wren=0 and both gnt=0 on every cycle.
